// File: rtl/servo_pkg.sv
// Shared types, default timing constants and the clamp helper for the servo bank.
package servo_pkg;

  typedef logic [15:0] us_t;
  typedef logic [16:0] us_wide_t;

  localparam int unsigned DEF_MIN_US    = 500;
  localparam int unsigned DEF_MAX_US    = 2500;
  localparam int unsigned DEF_CENTER_US = 1500;
  localparam int unsigned DEF_FRAME_US  = 20000;

  typedef enum logic [1:0] {
    BTN_NONE,
    BTN_UP,
    BTN_DN
  } btn_act_e;

  // Saturating clamp of a 17-bit intermediate into [lo, hi].
  function automatic us_t clamp_us(input us_wide_t v, input us_t lo, input us_t hi);
    if (v < us_wide_t'(lo)) return lo;
    if (v > us_wide_t'(hi)) return hi;
    return v[15:0];
  endfunction

endpackage

// File: rtl/servo_bank_if.sv
// Host write port of the servo bank: one-cycle strobe, target channel and width in us.
interface servo_bank_if #(
  parameter int unsigned CHAN_W = 2
) ();
  import servo_pkg::*;

  logic              wr_en;
  logic [CHAN_W-1:0] wr_chan;
  us_t               wr_data;

  modport master (output wr_en, wr_chan, wr_data);
  modport slave  (input  wr_en, wr_chan, wr_data);

endinterface

// File: rtl/servo_btn.sv
// Raw active-low button -> 2-FF synchroniser, debounce counter, one-cycle press event.
module servo_btn #(
  parameter int unsigned DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync;
  logic             level;
  logic             pressed;
  logic [CNT_W-1:0] cnt;

  assign level = ~sync[1];

  // Debounced state flips only after DEBOUNCE_CYC consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '1;
      pressed <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_n};
      press <= 1'b0;
      if (level == pressed) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        pressed <= level;
        press   <= level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/servo_bank.sv
// Multi-channel RC servo pulse generator: shared us timebase, per-channel target/active widths.
// Define SERVO_SLEW_EN to rate-limit active width changes to SLEW_US per frame.
module servo_bank
  import servo_pkg::*;
#(
  parameter int unsigned N_CHAN       = 4,
  parameter int unsigned CLK_MHZ      = 25,
  parameter int unsigned FRAME_US     = DEF_FRAME_US,
  parameter int unsigned MIN_US       = DEF_MIN_US,
  parameter int unsigned MAX_US       = DEF_MAX_US,
  parameter int unsigned CENTER_US    = DEF_CENTER_US,
  parameter int unsigned STEP_US      = 100,
  parameter int unsigned SLEW_US      = 20,
  parameter int unsigned DEBOUNCE_CYC = 250000,
  localparam int unsigned CHAN_W      = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_up_n,
  input  logic              btn_dn_n,
  input  logic              btn_sel_n,
  servo_bank_if.slave       host,
  output logic [CHAN_W-1:0] sel_chan,
  output logic              frame_start,
  output logic [N_CHAN-1:0] control
);

  localparam int unsigned PRE_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_MHZ - 1);
  localparam us_t FRAME_LAST = us_t'(FRAME_US - 1);
  localparam us_t MIN_W      = us_t'(MIN_US);
  localparam us_t MAX_W      = us_t'(MAX_US);
  localparam us_t CENTER_W   = us_t'(CENTER_US);
  localparam us_t STEP_W     = us_t'(STEP_US);
  localparam us_t SLEW_W     = us_t'(SLEW_US);

  if (N_CHAN < 1 || N_CHAN > 16) begin : g_bad_nchan
    $error("servo_bank: N_CHAN must be 1..16");
  end
  if (!(MIN_US <= CENTER_US && CENTER_US <= MAX_US && MAX_US <= FRAME_US && FRAME_US <= 65535))
  begin : g_bad_widths
    $error("servo_bank: need MIN_US <= CENTER_US <= MAX_US <= FRAME_US <= 65535");
  end
  if (CLK_MHZ < 1 || STEP_US < 1 || SLEW_US < 1 || DEBOUNCE_CYC < 1) begin : g_bad_rates
    $error("servo_bank: CLK_MHZ, STEP_US, SLEW_US and DEBOUNCE_CYC must be nonzero");
  end

  logic [PRE_W-1:0] presc;
  us_t              us_cnt;
  us_t              us_nxt;
  logic             tick;
  logic             frame_end;
  us_t              target     [N_CHAN];
  us_t              active     [N_CHAN];
  us_t              active_nxt [N_CHAN];

  logic     up_ev, dn_ev, sel_ev;
  btn_act_e act;
  us_t      t_sel;
  us_t      up_val, dn_val, host_val;
  logic     host_hit;

  servo_btn #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_up (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_up_n), .press(up_ev)
  );
  servo_btn #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_dn (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_dn_n), .press(dn_ev)
  );
  servo_btn #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_sel (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_sel_n), .press(sel_ev)
  );

`ifdef SERVO_SLEW_EN
  function automatic us_t slew_toward(input us_t a, input us_t t);
    if (t > a) return (t - a > SLEW_W) ? a + SLEW_W : t;
    return (a - t > SLEW_W) ? a - SLEW_W : t;
  endfunction
`endif

  assign tick      = (presc == PRE_LAST);
  assign frame_end = tick && (us_cnt == FRAME_LAST);

  // Next-state timebase and widths feed the output registers so that control and
  // frame_start are registered yet aligned with the counter they describe.
  always_comb begin
    us_nxt = us_cnt;
    if (tick) us_nxt = frame_end ? '0 : us_cnt + us_t'(1);
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      active_nxt[i] = active[i];
      if (frame_end) begin
`ifdef SERVO_SLEW_EN
        active_nxt[i] = slew_toward(active[i], target[i]);
`else
        active_nxt[i] = target[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      us_cnt      <= '0;
      frame_start <= 1'b0;
      control     <= '0;
      for (int unsigned i = 0; i < N_CHAN; i++) active[i] <= CENTER_W;
    end else begin
      presc       <= tick ? '0 : presc + PRE_W'(1);
      us_cnt      <= us_nxt;
      frame_start <= frame_end;
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        active[i]  <= active_nxt[i];
        control[i] <= (us_nxt < active_nxt[i]);
      end
    end
  end

  always_comb begin
    act = BTN_NONE;
    if (up_ev && !dn_ev) act = BTN_UP;
    else if (dn_ev && !up_ev) act = BTN_DN;
  end

  assign t_sel    = target[sel_chan];
  assign up_val   = clamp_us(us_wide_t'(t_sel) + us_wide_t'(STEP_W), MIN_W, MAX_W);
  assign dn_val   = clamp_us((t_sel >= STEP_W) ? us_wide_t'(t_sel - STEP_W) : '0, MIN_W, MAX_W);
  assign host_val = clamp_us(us_wide_t'(host.wr_data), MIN_W, MAX_W);
  assign host_hit = host.wr_en && (32'(host.wr_chan) < N_CHAN);

  // Host write takes priority over a button event landing on the same channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_chan <= '0;
      for (int unsigned i = 0; i < N_CHAN; i++) target[i] <= CENTER_W;
    end else begin
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        if (host_hit && host.wr_chan == CHAN_W'(i)) begin
          target[i] <= host_val;
        end else if (sel_chan == CHAN_W'(i) && act != BTN_NONE) begin
          target[i] <= (act == BTN_UP) ? up_val : dn_val;
        end
      end
      if (sel_ev) sel_chan <= (32'(sel_chan) == N_CHAN - 1) ? '0 : sel_chan + CHAN_W'(1);
    end
  end

endmodule

// File: tb/tb_servo_bank.sv
// Self-checking bench for servo_bank: frame timing, host writes, buttons, reset and slew.
module tb_servo_bank;
  localparam int unsigned NCH = 4;
  localparam int FRAME_CYC = 3000 * 2;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_up_n, btn_dn_n, btn_sel_n;
  logic [1:0] sel_chan;
  logic frame_start;
  logic [NCH-1:0] control;
  logic [2:0] sel5;
  logic frame5;
  logic [4:0] control5;

  servo_bank_if #(.CHAN_W(2)) bus ();
  servo_bank_if #(.CHAN_W(3)) bus5 ();

  servo_bank #(.N_CHAN(4), .CLK_MHZ(2), .FRAME_US(3000), .DEBOUNCE_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n), .btn_sel_n(btn_sel_n),
    .host(bus), .sel_chan(sel_chan), .frame_start(frame_start), .control(control)
  );

  servo_bank #(.N_CHAN(5), .CLK_MHZ(2), .FRAME_US(3000), .DEBOUNCE_CYC(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .btn_up_n(1'b1), .btn_dn_n(1'b1), .btn_sel_n(1'b1),
    .host(bus5), .sel_chan(sel5), .frame_start(frame5), .control(control5)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_tgt [NCH];
  int m5_tgt [5];
  int m_sel;
  int meas_hi [NCH];

  typedef struct {
    int chan;
    int data;
    int exp;
  } wr_vec_t;
  wr_vec_t vec [9];

  function automatic int clampi(input int v);
    if (v < 500) return 500;
    if (v > 2500) return 2500;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!frame_start && cycles < FRAME_CYC + 1000);
    if (!frame_start) begin
      checks++;
      errors++;
      $display("FAIL frame_wait: no frame_start after %0d cycles", cycles);
    end
  endtask

  // Call right after frame_start was sampled high; counts one whole frame.
  task automatic measure_frame(input int wr_at, input int wchan, input int wdata);
    int c;
    c = 0;
    for (int i = 0; i < NCH; i++) meas_hi[i] = 0;
    do begin
      for (int i = 0; i < NCH; i++) meas_hi[i] += int'(control[i]);
      if (c == wr_at) begin
        bus.wr_en = 1'b1;
        bus.wr_chan = 2'(wchan);
        bus.wr_data = 16'(wdata);
      end
      if (c == wr_at + 1) bus.wr_en = 1'b0;
      step();
      c++;
    end while (!frame_start && c < FRAME_CYC + 1000);
    check("frame_period", c, FRAME_CYC);
  endtask

  task automatic host_write(input int chan, input int data);
    bus.wr_en = 1'b1;
    bus.wr_chan = 2'(chan);
    bus.wr_data = 16'(data);
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic host_write5(input int chan, input int data);
    bus5.wr_en = 1'b1;
    bus5.wr_chan = 3'(chan);
    bus5.wr_data = 16'(data);
    step();
    bus5.wr_en = 1'b0;
  endtask

  // which: 0 up, 1 down, 2 select, 3 up+down together
  task automatic press(input int which);
    btn_up_n  = !(which == 0 || which == 3);
    btn_dn_n  = !(which == 1 || which == 3);
    btn_sel_n = !(which == 2);
    repeat (14) step();
    btn_up_n = 1'b1; btn_dn_n = 1'b1; btn_sel_n = 1'b1;
    repeat (14) step();
    if (which == 0) m_tgt[m_sel] = clampi(m_tgt[m_sel] + 100);
    if (which == 1) m_tgt[m_sel] = clampi(m_tgt[m_sel] - 100);
    if (which == 2) m_sel = (m_sel + 1) % NCH;
  endtask

  initial begin
    int cyc, ch, dat, exp;
    rst_n = 1'b0;
    btn_up_n = 1'b1; btn_dn_n = 1'b1; btn_sel_n = 1'b1;
    bus.wr_en = 1'b0; bus.wr_chan = '0; bus.wr_data = '0;
    bus5.wr_en = 1'b0; bus5.wr_chan = '0; bus5.wr_data = '0;
    for (int i = 0; i < NCH; i++) m_tgt[i] = 1500;
    for (int i = 0; i < 5; i++) m5_tgt[i] = 1500;
    m_sel = 0;
    repeat (4) step();
    check("reset_control", int'(control), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_sel_chan", int'(sel_chan), 0);
    rst_n = 1'b1;

    // Timebase and default widths
    wait_frame(cyc);
    check("first_frame_latency", cyc, FRAME_CYC);
    measure_frame(-1, 0, 0);
    for (int i = 0; i < NCH; i++) check($sformatf("center_width_ch%0d", i), meas_hi[i], 3000);

    // Mid-frame host write only takes effect at the next boundary
    measure_frame(1000, 2, 1000);
    for (int i = 0; i < NCH; i++) check($sformatf("write_frame_ch%0d", i), meas_hi[i], 3000);
    measure_frame(-1, 0, 0);
    for (int i = 0; i < NCH; i++)
      check($sformatf("next_frame_ch%0d", i), meas_hi[i], (i == 2) ? 2000 : 3000);
    m_tgt[2] = 1000;

    // Table-driven host writes with clamping
    vec[0] = '{2, 1000, 1000};
    vec[1] = '{0, 100, 500};
    vec[2] = '{1, 9000, 2500};
    vec[3] = '{3, 499, 500};
    vec[4] = '{3, 500, 500};
    vec[5] = '{0, 2500, 2500};
    vec[6] = '{0, 2501, 2500};
    vec[7] = '{1, 65535, 2500};
    vec[8] = '{2, 0, 500};
    for (int i = 0; i < 9; i++) begin
      host_write(vec[i].chan, vec[i].data);
      check($sformatf("table_wr%0d_ch%0d", i, vec[i].chan), int'(dut.target[vec[i].chan]), vec[i].exp);
      m_tgt[vec[i].chan] = vec[i].exp;
    end

    // Out-of-range channel on a 5-channel bank
    host_write5(5, 700);
    host_write5(7, 900);
    for (int i = 0; i < 5; i++) check($sformatf("ignored_wr_ch%0d", i), int'(dut5.target[i]), 1500);
    host_write5(4, 700);
    m5_tgt[4] = 700;
    check("valid_wr_ch4", int'(dut5.target[4]), 700);

    // Randomised host writes against the model
    for (int n = 0; n < 150; n++) begin
      ch = $urandom_range(0, NCH - 1);
      dat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(300, 2700);
      host_write(ch, dat);
      m_tgt[ch] = clampi(dat);
      check($sformatf("rand_wr%0d", n), int'(dut.target[ch]), m_tgt[ch]);
      ch = $urandom_range(0, 7);
      dat = $urandom_range(0, 65535);
      host_write5(ch, dat);
      if (ch < 5) m5_tgt[ch] = clampi(dat);
      for (int i = 0; i < 5; i++) check($sformatf("rand5_wr%0d_ch%0d", n, i), int'(dut5.target[i]), m5_tgt[i]);
    end

    // Buttons: select ch1, saturate up, saturate down
    host_write(1, 1500);
    m_tgt[1] = 1500;
    press(2);
    check("sel_after_one", int'(sel_chan), m_sel);
    for (int n = 0; n < 12; n++) begin
      press(0);
      check($sformatf("up%0d", n), int'(dut.target[1]), m_tgt[1]);
    end
    check("up_saturate", int'(dut.target[1]), 2500);
    for (int n = 0; n < 25; n++) begin
      press(1);
      check($sformatf("dn%0d", n), int'(dut.target[1]), m_tgt[1]);
    end
    check("dn_saturate", int'(dut.target[1]), 500);

    // Bounce of 7 cycles is rejected
    btn_up_n = 1'b0;
    repeat (7) step();
    btn_up_n = 1'b1;
    repeat (20) step();
    check("bounce_rejected", int'(dut.target[1]), 500);

    // Press latency: event 2+8 cycles after the input settles, target one cycle later
    btn_up_n = 1'b0;
    repeat (10) step();
    check("press_not_early", int'(dut.target[1]), 500);
    step();
    check("press_latency", int'(dut.target[1]), 600);
    btn_up_n = 1'b1;
    repeat (14) step();
    m_tgt[1] = 600;

    press(3);
    check("up_dn_together", int'(dut.target[1]), m_tgt[1]);

    // Host write coincident with an up event on the selected channel
    btn_up_n = 1'b0;
    repeat (10) step();
    host_write(1, 800);
    check("host_beats_button", int'(dut.target[1]), 800);
    btn_up_n = 1'b1;
    repeat (14) step();
    check("host_beats_button_hold", int'(dut.target[1]), 800);
    m_tgt[1] = 800;

    for (int n = 0; n < 3; n++) begin
      press(2);
      check($sformatf("sel_step%0d", n), int'(sel_chan), m_sel);
    end
    check("sel_wrapped", int'(sel_chan), 0);

    // Reset in the middle of a pulse
    wait_frame(cyc);
    repeat (100) step();
    check("pre_reset_control", int'(control), 4'hF);
    rst_n = 1'b0;
    #1;
    check("reset_async_control", int'(control), 0);
    check("reset_async_frame_start", int'(frame_start), 0);
    repeat (3) step();
    check("reset_sel", int'(sel_chan), 0);
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("reset_target_ch%0d", i), int'(dut.target[i]), 1500);
      check($sformatf("reset_active_ch%0d", i), int'(dut.active[i]), 1500);
      m_tgt[i] = 1500;
    end
    rst_n = 1'b1;
    wait_frame(cyc);
    check("post_reset_frame", cyc, FRAME_CYC);

    // Width change 1500 -> 1600, rate-limited when slew is built in
    host_write(0, 1600);
    for (int k = 1; k <= 5; k++) begin
      wait_frame(cyc);
`ifdef SERVO_SLEW_EN
      exp = (1500 + 20 * k > 1600) ? 1600 : 1500 + 20 * k;
`else
      exp = 1600;
`endif
      check($sformatf("slew_frame%0d", k), int'(dut.active[0]), exp);
    end
    measure_frame(-1, 0, 0);
    check("final_width_ch0", meas_hi[0], 3200);
    for (int i = 1; i < NCH; i++) check($sformatf("final_width_ch%0d", i), meas_hi[i], 3000);
    check("final_active_ch0", int'(dut.active[0]), 1600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
